// File: rtl/iterative_multiplier.sv
// Multi-cycle shift-and-add multiplier (MUL/UMULL/SMULL) with start/busy/done handshake.
// One N-bit carry-lookahead adder is reused every RUN cycle; signed operands go through magnitude + final negate.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gg,
    output logic       gp
);
    logic [3:0] p, g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;
endmodule

// N must be a multiple of 4 and at least 8.
module carry_lookahead_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    localparam int NG = N / 4;

    logic [NG:0]   c;
    logic [NG-1:0] gg, gp;

    assign c[0] = cin;

    for (genvar i = 0; i < NG; i++) begin : g_blk
        cla4 u_blk (
            .a  (a[4*i +: 4]),
            .b  (b[4*i +: 4]),
            .cin(c[i]),
            .s  (s[4*i +: 4]),
            .gg (gg[i]),
            .gp (gp[i])
        );
        // Group carries ripple between 4-bit lookahead blocks.
        assign c[i+1] = gg[i] | (gp[i] & c[i]);
    end

    assign cout = c[NG];
endmodule

module iterative_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result,
    output logic           flag_n,
    output logic           flag_z
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0]  CNT_ONE  = 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0]   ONE_N    = 1;
    localparam logic [2*N-1:0] ONE_2N   = 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    typedef struct packed {
        logic         neg;
        logic [N-1:0] mcand;
        logic [N-1:0] mplr;
    } load_t;

    state_t          state, state_nxt;
    logic [N-1:0]    mcand, acc_hi, prod_lo;
    logic            neg;
    logic [CW-1:0]   count;

    logic [N-1:0]    addend, sum;
    logic            cout;
    logic [2*N-1:0]  prod_nxt, prod_neg;
    logic            accept, last;
    logic            res_wr;
    logic [2*N-1:0]  res_val;
    load_t           ld;

    // Magnitudes: -2^(N-1) negates to itself, which reads correctly as unsigned 2^(N-1).
    always_comb begin
        ld.neg   = is_signed & (A[N-1] ^ B[N-1]);
        ld.mcand = (is_signed && A[N-1]) ? (~A + ONE_N) : A;
        ld.mplr  = (is_signed && B[N-1]) ? (~B + ONE_N) : B;
    end

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (count == CNT_LAST);
    assign addend = prod_lo[0] ? mcand : '0;

    carry_lookahead_adder #(.N(N)) u_add (
        .a   (acc_hi),
        .b   (addend),
        .cin (1'b0),
        .s   (sum),
        .cout(cout)
    );

    assign prod_nxt = {cout, sum, prod_lo[N-1:1]};
    assign prod_neg = ~{acc_hi, prod_lo} + ONE_2N;

    assign res_wr  = (state == RUN && last && !neg) || (state == FIX);
    assign res_val = (state == FIX) ? prod_neg : prod_nxt;

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = neg ? FIX : DONE;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            acc_hi  <= '0;
            prod_lo <= '0;
            neg     <= 1'b0;
            count   <= '0;
            result  <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b1;
        end else begin
            if (accept) begin
                mcand   <= ld.mcand;
                prod_lo <= ld.mplr;
                acc_hi  <= '0;
                neg     <= ld.neg;
                count   <= '0;
            end else if (state == RUN) begin
                {acc_hi, prod_lo} <= prod_nxt;
                count             <= count + CNT_ONE;
            end
            if (res_wr) begin
                result <= res_val;
                flag_n <= res_val[2*N-1];
                flag_z <= (res_val == '0);
            end
        end
    end
endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed bench for iterative_multiplier: latency-countdown reference model checked every cycle,
// plus literal expected products, latencies and flags for each vector.

module tb_iterative_multiplier;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          is_signed = 1'b0;
    logic [N-1:0]  A = '0;
    logic [N-1:0]  B = '0;
    logic          busy, done, flag_n, flag_z;
    logic [2*N-1:0] result;

    iterative_multiplier #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_signed(is_signed),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flag_n   (flag_n),
        .flag_z   (flag_z)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: product by plain 64-bit arithmetic, latency N (+1 when the result is negated).
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'h0, a};
        xb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return xa * xb;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        return (s && (a[31] ^ b[31])) ? N + 1 : N;
    endfunction

    logic        m_busy = 1'b0, m_done = 1'b0, m_fn = 1'b0, m_fz = 1'b1;
    logic [63:0] m_res = '0, m_pend = '0;
    int          m_rem = 0;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_fn = 1'b0; m_fz = 1'b1; m_rem = 0;
        end else if (m_busy) begin
            m_done = 1'b0;
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_res = m_pend; m_fn = m_pend[63]; m_fz = (m_pend == 0);
            end
        end else if (start) begin
            m_pend = ref_mul(A, B, is_signed);
            m_rem  = ref_lat(A, B, is_signed);
            m_busy = 1'b1;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("cyc busy", busy, m_busy);
            chk("cyc done", done, m_done);
            chk("cyc result", result, m_res);
            chk("cyc flag_n", flag_n, m_fn);
            chk("cyc flag_z", flag_z, m_fz);
        end
    end

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        A = a; B = b; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; is_signed = ~s;
    endtask

    task automatic wait_done(input string name, input int i0, input logic [63:0] exp, input int lat);
        int i;
        i = i0;
        while (!done && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk({name, " latency"}, i, lat);
        chk({name, " result"}, result, exp);
    endtask

    initial begin
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vs [8];
        logic [63:0] vr [8];
        int          vl [8];
        logic        vn [8];
        logic        vz [8];

        va[0] = 32'd3;          vb[0] = 32'd5;          vs[0] = 0; vr[0] = 64'h0000_0000_0000_000F; vl[0] = 32; vn[0] = 0; vz[0] = 0;
        va[1] = 32'hFFFF_FFFF;  vb[1] = 32'hFFFF_FFFF;  vs[1] = 0; vr[1] = 64'hFFFF_FFFE_0000_0001; vl[1] = 32; vn[1] = 1; vz[1] = 0;
        va[2] = 32'hFFFF_FFFD;  vb[2] = 32'd7;          vs[2] = 1; vr[2] = 64'hFFFF_FFFF_FFFF_FFEB; vl[2] = 33; vn[2] = 1; vz[2] = 0;
        va[3] = 32'h8000_0000;  vb[3] = 32'h8000_0000;  vs[3] = 1; vr[3] = 64'h4000_0000_0000_0000; vl[3] = 32; vn[3] = 0; vz[3] = 0;
        va[4] = 32'd0;          vb[4] = 32'hFFFF_FFFB;  vs[4] = 1; vr[4] = 64'h0;                   vl[4] = 33; vn[4] = 0; vz[4] = 1;
        va[5] = 32'hFFFF_FFFF;  vb[5] = 32'hFFFF_FFFF;  vs[5] = 1; vr[5] = 64'h1;                   vl[5] = 32; vn[5] = 0; vz[5] = 0;
        va[6] = 32'd5;          vb[6] = 32'h8000_0000;  vs[6] = 1; vr[6] = 64'hFFFF_FFFD_8000_0000; vl[6] = 33; vn[6] = 1; vz[6] = 0;
        va[7] = 32'h8000_0000;  vb[7] = 32'd3;          vs[7] = 0; vr[7] = 64'h0000_0001_8000_0000; vl[7] = 32; vn[7] = 0; vz[7] = 0;

        @(negedge clk);
        armed = 1'b1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset flag_z", flag_z, 1);
        chk("reset flag_n", flag_n, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            chk("model pins vector", ref_mul(va[v], vb[v], vs[v]), vr[v]);
            start_op(va[v], vb[v], vs[v]);
            chk("busy after start", busy, 1);
            wait_done($sformatf("vec%0d", v), 0, vr[v], vl[v]);
            chk($sformatf("vec%0d flag_n", v), flag_n, vn[v]);
            chk($sformatf("vec%0d flag_z", v), flag_z, vz[v]);
            @(negedge clk);
            chk("done one cycle", done, 0);
        end

        // Start while busy is ignored.
        start_op(32'd3, 32'd5, 1'b0);
        repeat (4) @(negedge clk);
        A = 32'd9; B = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("repulse", 5, 64'hF, 32);

        // Back-to-back start in the DONE cycle; old result held meanwhile.
        start_op(32'd2, 32'd2, 1'b0);
        chk("b2b hold old", result, 64'hF);
        chk("b2b done drop", done, 0);
        wait_done("b2b", 0, 64'd4, 32);
        @(negedge clk);

        // Reset mid-operation aborts with no done.
        start_op(32'd3, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort result", result, 0);
        chk("abort flag_z", flag_z, 1);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("abort no done", seen, 0);
        end
        start_op(32'd6, 32'd7, 1'b0);
        wait_done("after abort", 0, 64'd42, 32);
        @(negedge clk);
        @(negedge clk);

        armed = 1'b0;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/iterative_multiplier.md
Name: iterative_multiplier

Overview:
- Multi-cycle shift-and-add multiplier for the execute stage's MUL/UMULL/SMULL path.
- Consumes the sum and carry-out of one N-bit carry_lookahead_adder instance once per cycle.
- Produces a 2N-bit product with start/busy/done handshake and N/Z flags for flag-setting multiplies.
- Sits beside the ALU; the control unit stalls the pipeline while busy is high.

Parameters:
N, 32, operand width; must be a multiple of 4 and at least 8, as required by the carry_lookahead_adder.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
A  input  N  multiplicand; captured with start
B  input  N  multiplier; captured with start
busy  output  1  high in RUN and FIX
done  output  1  one-cycle pulse when result is valid
result  output  2N  product; held until the next accepted start
flag_n  output  1  result[2N-1]; valid with done, held with result
flag_z  output  1  1 when result == 0; valid with done, held with result

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, result=0, flag_n=0, flag_z=1, internal registers cleared.
- Reset asserted mid-operation aborts the operation on that edge. No done is produced for the aborted operation.
- States:
  - IDLE: start=1 loads operands and goes to RUN.
  - RUN: performs N iterations, then goes to FIX if negation is needed, else DONE.
  - FIX: one cycle, negates the product, then goes to DONE.
  - DONE: done=1 for one cycle; start accepted exactly as in IDLE, else goes to IDLE.
- Load, on the edge where start is accepted:
  - mcand = is_signed ? |A| : A; mplr = is_signed ? |B| : B.
  - |x| is two's-complement negation when x[N-1]=1. |-2^(N-1)| is the unsigned value 2^(N-1).
  - neg = is_signed & (A[N-1] ^ B[N-1]).
  - acc_hi=0, prod_lo=mplr, count=0.
- Each RUN edge:
  - Adder inputs are acc_hi and (prod_lo[0] ? mcand : 0), with Cin=0.
  - {acc_hi, prod_lo} <= {Cout, S, prod_lo} >> 1, i.e. shift the (2N+1)-bit value right by one.
  - count increments. On the edge where count==N-1 (the Nth iteration), leave RUN.
- Leaving RUN:
  - If neg=0: result <= final {acc_hi, prod_lo}; go to DONE.
  - If neg=1: go to FIX. In FIX, result <= 2N-bit two's complement of {acc_hi, prod_lo} (invert plus 1, carry through all 2N bits); go to DONE.
- Timing, with start accepted at edge k:
  - Result and flags are registered at edge k+N (unsigned or non-negated) or k+N+1 (negated).
  - done is high during the following cycle.
  - busy is high from edge k to the edge that enters DONE.
- Input rules:
  - start while busy is ignored, with no queuing.
  - A, B and is_signed changing while busy have no effect.
- Back-to-back: start in the DONE cycle is accepted. done still pulses for exactly one cycle. result holds the old value until the new operation's result edge.
- flag_n and flag_z update only on result-write edges.

Test Plan:
- Unsigned 3×5, start at edge k, N=32 -> result=0x000000000000000F at edge k+32; done high one cycle; busy high edges k..k+32; flag_z=0, flag_n=0.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF -> result=0xFFFFFFFE00000001 (exercises Cout on every iteration); flag_n=1.
- Signed -3 (0xFFFFFFFD)×7 -> result=0xFFFFFFFFFFFFFFEB; done one cycle later than unsigned (edge k+33). Signed 0x80000000×0x80000000 -> 0x4000000000000000 with no FIX cycle.
- Signed 0×(-5) -> result=0, flag_z=1, flag_n=0; FIX path taken; result is not negative zero.
- Re-pulse start at k+5 with different operands -> ignored, first product unchanged. Start in the DONE cycle with 2×2 -> second done at +32 edges, result=4.
- Assert reset at k+10 -> busy=0, done never pulses, result=0, flag_z=1. A following start with 6×7 -> 42.
